// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Shared definitions for the snake game blocks. It holds the
//               playfield geometry defaults, the food manager state encoding,
//               coordinate types and the LFSR tap constant with its step
//               function.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

  localparam int GRID_W = 32;   // playfield width in cells
  localparam int GRID_H = 24;   // playfield height in cells
  localparam int XW     = 5;    // column coordinate width
  localparam int YW     = 5;    // row coordinate width

  // Galois feedback taps for the 16-bit right-shifting LFSR.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [XW-1:0] xcoord_t;
  typedef logic [YW-1:0] ycoord_t;

  typedef enum logic [1:0] {
    WATCH = 2'd0,   // food placed, waiting for the head to land on it
    DRAW  = 2'd1,   // drawing LFSR candidates until one is on the grid
    CHECK = 2'd2    // waiting for the body store to answer the query
  } fm_state_t;

  // One Galois step: shift right and fold the taps in when a 1 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/food_manager_if.sv
`default_nettype none
// ============================================================================
// Module      : food_manager_if
// Description : Occupancy query handshake between the food manager (master)
//               and the snake body store (slave).
//   occ_req   : 1-cycle query strobe (master -> slave)
//   occ_x/y   : queried cell, held until occ_valid (master -> slave)
//   occ_valid : response strobe, at least 1 cycle after occ_req (slave -> master)
//   occ_hit   : cell occupied by the snake, valid with occ_valid (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface food_manager_if #(
  parameter int XW = snake_pkg::XW,
  parameter int YW = snake_pkg::YW
);
  logic          occ_req;
  logic [XW-1:0] occ_x;
  logic [YW-1:0] occ_y;
  logic          occ_valid;
  logic          occ_hit;

  modport master (output occ_req, occ_x, occ_y, input occ_valid, occ_hit);
  modport slave  (input occ_req, occ_x, occ_y, output occ_valid, occ_hit);
endinterface
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : Free-running 16-bit Galois LFSR (taps 16'hB400, shift right).
//               Advances on every clock; reusable by any game block that
//               needs cheap pseudo-random bits.
//   clk    : system clock
//   resetn : asynchronous active-low reset, loads SEED
//   value  : current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1   // must be nonzero
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [15:0] value
);
  import snake_pkg::*;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value <= SEED;
    end else begin
      value <= lfsr_step(value);
    end
  end

endmodule
`default_nettype wire

// File: rtl/food_manager.sv
`default_nettype none
// ============================================================================
// Module      : food_manager
// Description : Holds the current food cell, detects the snake head landing
//               on it at a move tick, pulses score_inc/grow, then relocates
//               the food to a pseudo-random free cell by querying the snake
//               body store.
//   clk, resetn          : clock, asynchronous active-low reset
//   move_tick            : 1-cycle pulse, head_x/head_y just updated
//   head_x, head_y       : snake head cell
//   occ (master)         : occupancy query handshake to the body store
//   food_x, food_y       : current food cell
//   food_valid           : food placed and drawable
//   score_inc, grow      : coincident 1-cycle pulses per food eaten
//   place_timeout        : sticky, too many rejected candidates in one search
// Revision    : 1.0 - initial release
// ============================================================================
module food_manager #(
  parameter int          GRID_W    = snake_pkg::GRID_W,
  parameter int          GRID_H    = snake_pkg::GRID_H,
  parameter int          XW        = snake_pkg::XW,
  parameter int          YW        = snake_pkg::YW,
  parameter int          INIT_X    = 20,
  parameter int          INIT_Y    = 12,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 255
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          move_tick,
  input  logic [XW-1:0] head_x,
  input  logic [YW-1:0] head_y,
  food_manager_if.master occ,
  output logic [XW-1:0] food_x,
  output logic [YW-1:0] food_y,
  output logic          food_valid,
  output logic          score_inc,
  output logic          grow,
  output logic          place_timeout
);
  import snake_pkg::*;

  // One extra bit beyond what MAX_TRIES needs so "exceeded" is representable.
  localparam int            TW        = $clog2(MAX_TRIES + 1) + 1;
  localparam logic [TW-1:0] TRY_LIMIT = TW'(MAX_TRIES);
  localparam logic [TW-1:0] TRY_SAT   = '1;
  localparam logic [XW:0]   GW        = (XW + 1)'(GRID_W);
  localparam logic [YW:0]   GH        = (YW + 1)'(GRID_H);

  fm_state_t     state, state_n;
  logic [15:0]   lfsr;
  logic [XW-1:0] cand_x;
  logic [YW-1:0] cand_y;
  logic          cand_ok;
  logic          query_is_old;
  logic [TW-1:0] tries;
  logic          do_eat, do_query, do_reject, do_commit;
  logic          unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .value  (lfsr)
  );

  assign cand_x      = lfsr[XW-1:0];
  assign cand_y      = lfsr[XW+YW-1:XW];
  assign unused_lfsr = ^lfsr[15:XW+YW];
  assign cand_ok     = ({1'b0, cand_x} < GW) && ({1'b0, cand_y} < GH);

  // occ_x/occ_y still hold the candidate while in CHECK and food_x/food_y
  // still hold the old cell, so this flags a relocation onto the same cell.
  assign query_is_old = (occ.occ_x == food_x) && (occ.occ_y == food_y);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= WATCH;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    do_eat    = 1'b0;
    do_query  = 1'b0;
    do_reject = 1'b0;
    do_commit = 1'b0;
    case (state)
      WATCH: begin
        if (move_tick && food_valid && head_x == food_x && head_y == food_y) begin
          do_eat  = 1'b1;
          state_n = DRAW;
        end
      end
      DRAW: begin
        if (cand_ok) begin
          do_query = 1'b1;
          state_n  = CHECK;
        end else begin
          do_reject = 1'b1;
        end
      end
      CHECK: begin
        if (occ.occ_valid) begin
          if (occ.occ_hit || query_is_old) begin
            do_reject = 1'b1;
            state_n   = DRAW;
          end else begin
            do_commit = 1'b1;
            state_n   = WATCH;
          end
        end
      end
      default: state_n = WATCH;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      food_x        <= XW'(INIT_X);
      food_y        <= YW'(INIT_Y);
      food_valid    <= 1'b1;
      score_inc     <= 1'b0;
      grow          <= 1'b0;
      occ.occ_req   <= 1'b0;
      occ.occ_x     <= '0;
      occ.occ_y     <= '0;
      tries         <= '0;
      place_timeout <= 1'b0;
    end else begin
      score_inc   <= do_eat;
      grow        <= do_eat;
      occ.occ_req <= do_query;
      if (do_eat) begin
        food_valid <= 1'b0;
        tries      <= '0;
      end
      if (do_query) begin
        occ.occ_x <= cand_x;
        occ.occ_y <= cand_y;
      end
      if (do_reject) begin
        if (tries != TRY_SAT) begin
          tries <= tries + TW'(1);
        end
        // Post-increment count would exceed the limit; search keeps going.
        if (tries >= TRY_LIMIT) begin
          place_timeout <= 1'b1;
        end
      end
      if (do_commit) begin
        food_x     <= occ.occ_x;
        food_y     <= occ.occ_y;
        food_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/food_manager.md
Name: food_manager

Overview:
- Upstream producer of the 1-cycle `score_inc` pulse consumed by the score counter/HEX stage.
- Holds the current food cell, detects the snake head landing on it at each move tick, and pulses `score_inc` and `grow`.
- Then relocates the food to a pseudo-random free cell, using a free-running LFSR and an occupancy-query handshake to the snake body store.

Parameters:
- GRID_W, 32, playfield width in cells
- GRID_H, 24, playfield height in cells
- XW, 5, x coordinate width (ceil log2 GRID_W)
- YW, 5, y coordinate width (ceil log2 GRID_H)
- INIT_X, 20, food x after reset
- INIT_Y, 12, food y after reset
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)
- MAX_TRIES, 255, rejected candidates before `place_timeout` sets

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- move_tick  in  1  1-cycle pulse: head_x/head_y just updated
- head_x  in  XW  snake head column
- head_y  in  YW  snake head row
- occ_req  out  1  1-cycle occupancy query strobe
- occ_x  out  XW  queried column, held until occ_valid
- occ_y  out  YW  queried row, held until occ_valid
- occ_valid  in  1  query response strobe, latency ≥1 cycle
- occ_hit  in  1  cell occupied by snake, sampled with occ_valid
- food_x  out  XW  current food column
- food_y  out  YW  current food row
- food_valid  out  1  food placed and drawable
- score_inc  out  1  1-cycle pulse per food eaten
- grow  out  1  1-cycle pulse, coincident with score_inc
- place_timeout  out  1  sticky: MAX_TRIES exceeded during one placement

Behaviour:
- Reset (async, resetn=0):
  - food_x=INIT_X, food_y=INIT_Y, food_valid=1.
  - score_inc=grow=occ_req=0, occ_x=occ_y=0, place_timeout=0.
  - LFSR=LFSR_SEED, try counter=0, state=WATCH.
  - Reset mid-placement aborts any query; a late occ_valid after reset is ignored.
- LFSR:
  - 16-bit Galois, taps 16'hB400, shift right.
  - Advances every cycle in every state.
  - Candidate: x=lfsr[XW-1:0], y=lfsr[XW+YW-1:XW].
- States:
  - WATCH:
    - On move_tick with head_x==food_x and head_y==food_y: next cycle score_inc=1, grow=1 (exactly one cycle), food_valid=0, try counter=0, go to DRAW.
    - move_tick without a match, or a match without move_tick: no action.
  - DRAW, each cycle:
    - If candidate x≥GRID_W or y≥GRID_H: reject, increment try counter, stay in DRAW.
    - Else: latch the candidate into occ_x/occ_y, assert occ_req for exactly one cycle, go to CHECK.
  - CHECK:
    - Wait for occ_valid.
    - occ_hit=1: increment try counter, go to DRAW.
    - occ_hit=0: food_x/food_y=candidate, food_valid=1 the next cycle, go to WATCH.
    - Also reject (back to DRAW) if the candidate equals the old food cell.
- Try counter:
  - Saturating, width ceil log2(MAX_TRIES+1)+1.
  - When it exceeds MAX_TRIES: place_timeout←1 (sticky until reset); searching continues.
- Ignore rules:
  - move_tick in DRAW/CHECK is ignored; food_valid=0 prevents scoring.
  - occ_valid outside CHECK is ignored.
  - occ_valid in the same cycle as occ_req is not permitted by the body store; the bench asserts against it.
- Latency:
  - Tick to score_inc: 1 cycle.
  - Tick to food_valid=1 (best case): 4 cycles, with 1-cycle occupancy latency and first candidate accepted.
- Outputs: food_x/food_y change only on commit and are stable while food_valid=1.

Decomposition:
- Package `snake_pkg`:
  - GRID_W/GRID_H/XW/YW defaults
  - state enum {WATCH, DRAW, CHECK}
  - LFSR taps constant
  - coordinate typedefs
- One sub-module `lfsr16` (seed parameter, always-advancing, async active-low reset), reusable by other game blocks.

Test Plan:
1. Reset release, head at (3,4), move_tick, occupancy responder idle:
   - food stays (20,12), food_valid=1.
   - score_inc never pulses; occ_req never asserts.
2. Head (20,12) with move_tick:
   - Next cycle score_inc=grow=1 for one cycle, food_valid=0.
   - occ_req rises within DRAW.
   - Responder answers occ_hit=0 after 1 cycle.
   - food_valid=1 at new in-range (x<32, y<24) coords ≠(20,12).
3. Responder returns occ_hit=1 for the first 3 queries, 0 thereafter:
   - Exactly 4 occ_req pulses.
   - Final food equals the 4th queried cell.
   - score_inc pulsed once only.
4. Responder always occ_hit=1:
   - place_timeout rises after MAX_TRIES=255 rejections and stays 1.
   - food_valid stays 0 while searching; extra move_ticks at the old food cell give no score_inc.
5. resetn low while in CHECK with occ_req outstanding:
   - Immediately food=(20,12), food_valid=1, place_timeout=0.
   - A subsequent stray occ_valid is ignored; state is WATCH.
6. 120 consecutive eats driven through the score path:
   - 120 score_inc pulses, none back-to-back.
   - Every committed food cell in range and never an occupied cell (scoreboard).
